multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
Multicycle control unit for the RV64 subset datapath. It decodes the latched instruction register fields and sequences PC, IR, A/B/ULAOut, data-memory and register-bank enables, plus the ALU and mux selects. It sits directly upstream of the CPU datapath and drives every control input that the datapath consumes.

Parameters:
MEM_WAIT_CYCLES, 1, extra wait cycles after a memory read is issued (instruction fetch and load); range 0..7.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
igual  in  1  ALU equality flag (A==B), valid in BRANCH
pc_write  out  1  PC load enable
pc_src  out  1  0: PC <= ALU S; 1: PC <= ULAOut register
pc_old_load  out  1  latch current PC into old-PC register
ir_load  out  1  IR load enable
ab_load  out  1  Reg_A/Reg_B load enable
ulaout_load  out  1  ULAOut register load enable
mem_write  out  1  data-memory write
reg_write  out  1  register-bank write
wb_sel  out  1  0: ULAOut, 1: memory-data register
ula_seletor  out  3  ALU op
mux_a_sel  out  3  0 PC, 1 RegA, 2 zero, 3 old PC
mux_b_sel  out  3  0 RegB, 1 const 4, 2 imm
halted  out  1  illegal opcode trapped
state_o  out  4  current state (debug)

Behaviour:
- All outputs are combinational (Moore) from the state register, except pc_write in BRANCH, which depends on the condition. All enables are 0 outside the listed states.
- Reset (reset==0, async): state=FETCH, wait counter=0, halted=0, all enables 0. Reset asserted mid-instruction aborts the instruction with no partial writes after the edge.
- ALU codes (package): ADD=3'd1, SUB=3'd2.
- FETCH:
  - pc_old_load=1 in the first cycle only.
  - Stay for MEM_WAIT_CYCLES cycles.
  - On the final cycle: ir_load=1, pc_write=1, pc_src=0, mux_a=PC, mux_b=4, ALU ADD. Go to DECODE.
- DECODE:
  - ab_load=1, ulaout_load=1, mux_a=old PC, mux_b=imm, ADD (branch target).
  - Next state by opcode: 0110011 R -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> MEM_ADDR; 1100011 -> BRANCH; 0110111 -> LUI.
  - Any other opcode -> HALT.
- EXEC_R: mux_a=RegA, mux_b=RegB, ulaout_load=1. Op is SUB if funct3==0 and funct7_5==1, else ADD. Go to WB_ALU.
- EXEC_I: RegA + imm, ADD, ulaout_load=1. Go to WB_ALU.
- LUI: zero + imm, ADD, ulaout_load=1. Go to WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0. Go to FETCH.
- MEM_ADDR: RegA + imm, ADD, ulaout_load=1. Load -> MEM_READ; store -> MEM_WRITE.
- MEM_WRITE: mem_write=1 for exactly one cycle. Go to FETCH.
- MEM_READ: wait MEM_WAIT_CYCLES cycles (counter reused), then WB_MEM.
- WB_MEM: reg_write=1, wb_sel=1. Go to FETCH.
- BRANCH: RegA - RegB, SUB. Condition: beq (funct3=000) is igual; bne (001) is !igual; other funct3 values are not-taken. When taken: pc_write=1, pc_src=1. Go to FETCH.
- HALT: halted=1, all enables 0; stays here until reset.
- Latency with MEM_WAIT_CYCLES=1:
  - R/I/LUI: 4 cycles
  - branch: 3 cycles
  - store: 4 cycles
  - load: 6 cycles
- Wait counter: 3 bits, saturates at MEM_WAIT_CYCLES, cleared on every state exit. With MEM_WAIT_CYCLES=0, FETCH and MEM_READ each take 1 cycle.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: adds output instr_retired[31:0], incremented on each transition into FETCH from a completing state (not from reset). It wraps modulo 2^32 and clears on reset.
- Undefined: the port exists and is tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, EXEC_I, LUI, WB_ALU, MEM_ADDR, MEM_READ, MEM_WRITE, WB_MEM, BRANCH, HALT)
  - opcode constants
  - ULA op codes
  - mux select constants
- Optional sub-module ctrl_wait_counter: programmable wait counter with done pulse.

Test Plan:
- Reset low mid-EXEC_R -> state_o=FETCH, reg_write=0, halted=0 immediately; first post-reset FETCH asserts pc_old_load.
- opcode=0110011, funct3=0, funct7_5=1 -> exactly 4 cycles FETCH..WB_ALU; ula_seletor=SUB in EXEC_R; reg_write high for 1 cycle.
- opcode=0000011, MEM_WAIT_CYCLES=1 -> 6-cycle sequence; wb_sel=1 only in WB_MEM; mem_write never asserted.
- opcode=1100011, funct3=001, igual=1 -> pc_write=0 in BRANCH; with igual=0 -> pc_write=1, pc_src=1.
- opcode=1111111 -> HALT after DECODE; halted=1 held for 100 cycles; enables stay 0.
- CTRL_PERF_CNT_EN defined, 3 addi instructions -> instr_retired=3; undefined -> 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multicycle RV64-subset control unit:
// state encoding, opcodes, ALU op codes and datapath mux selects.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        LUI       = 4'd4,
        WB_ALU    = 4'd5,
        MEM_ADDR  = 4'd6,
        MEM_READ  = 4'd7,
        MEM_WRITE = 4'd8,
        WB_MEM    = 4'd9,
        BRANCH    = 4'd10,
        HALT      = 4'd11
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;

    localparam logic [2:0] MUXA_PC    = 3'd0;
    localparam logic [2:0] MUXA_REGA  = 3'd1;
    localparam logic [2:0] MUXA_ZERO  = 3'd2;
    localparam logic [2:0] MUXA_OLDPC = 3'd3;

    localparam logic [2:0] MUXB_REGB = 3'd0;
    localparam logic [2:0] MUXB_FOUR = 3'd1;
    localparam logic [2:0] MUXB_IMM  = 3'd2;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Unsupported branch flavours (blt, bge, ...) simply fall through.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic igual);
        logic taken;
        taken = 1'b0;
        if (funct3 == F3_BEQ) taken = igual;
        else if (funct3 == F3_BNE) taken = ~igual;
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control unit (master) and the
// CPU datapath (slave): decoded IR fields in, every datapath control out.
interface multicycle_ctrl_fsm_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        igual;
    logic        pc_write;
    logic        pc_src;
    logic        pc_old_load;
    logic        ir_load;
    logic        ab_load;
    logic        ulaout_load;
    logic        mem_write;
    logic        reg_write;
    logic        wb_sel;
    logic [2:0]  ula_seletor;
    logic [2:0]  mux_a_sel;
    logic [2:0]  mux_b_sel;
    logic        halted;
    logic [3:0]  state_o;
    logic [31:0] instr_retired;

    modport master (
        input  opcode, funct3, funct7_5, igual,
        output pc_write, pc_src, pc_old_load, ir_load, ab_load, ulaout_load,
               mem_write, reg_write, wb_sel, ula_seletor, mux_a_sel, mux_b_sel,
               halted, state_o, instr_retired
    );

    modport slave (
        output opcode, funct3, funct7_5, igual,
        input  pc_write, pc_src, pc_old_load, ir_load, ab_load, ulaout_load,
               mem_write, reg_write, wb_sel, ula_seletor, mux_a_sel, mux_b_sel,
               halted, state_o, instr_retired
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_wait_counter.sv
// Cycles-in-state counter for memory waits: saturates at MAX_COUNT, is
// cleared whenever the FSM leaves a state, and flags when target is reached.
module multicycle_ctrl_fsm_wait_counter #(
    parameter int unsigned MAX_COUNT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear_i,
    input  logic [2:0] target_i,
    output logic [2:0] count_o,
    output logic       done_o
);
    localparam logic [2:0] SAT = 3'(MAX_COUNT);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) count_d = 3'd0;
        else if (count_q < SAT) count_d = count_q + 3'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= 3'd0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;
    assign done_o  = (count_q >= target_i);
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the RV64-subset datapath (Moore outputs).
// Optional: define CTRL_PERF_CNT_EN to enable the instr_retired counter.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_ctrl_fsm_if.master bus
);
    // FETCH issues its read in the first cycle, so it needs one cycle less than MEM_READ.
    localparam logic [2:0] FETCH_LAST = (MEM_WAIT_CYCLES == 0) ? 3'd0 : 3'(MEM_WAIT_CYCLES - 1);
    localparam logic [2:0] READ_LAST  = 3'(MEM_WAIT_CYCLES);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] waitCount;
    logic [2:0] waitTarget;
    logic       waitDone;

    assign waitTarget = (state_q == MEM_READ) ? READ_LAST : FETCH_LAST;

    multicycle_ctrl_fsm_wait_counter #(
        .MAX_COUNT(MEM_WAIT_CYCLES)
    ) u_wait (
        .clock   (clock),
        .reset   (reset),
        .clear_i (state_d != state_q),
        .target_i(waitTarget),
        .count_o (waitCount),
        .done_o  (waitDone)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     if (waitDone) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_R:               state_d = EXEC_R;
                    OP_I:               state_d = EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
                    OP_BRANCH:          state_d = BRANCH;
                    OP_LUI:             state_d = LUI;
                    default:            state_d = HALT;
                endcase
            end
            EXEC_R, EXEC_I, LUI: state_d = WB_ALU;
            MEM_ADDR:  state_d = (bus.opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (waitDone) state_d = WB_MEM;
            WB_ALU, MEM_WRITE, WB_MEM, BRANCH: state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = FETCH;
        endcase
    end

    // Outputs are forced quiet while reset is held so no write leaks out.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.pc_src      = 1'b0;
        bus.pc_old_load = 1'b0;
        bus.ir_load     = 1'b0;
        bus.ab_load     = 1'b0;
        bus.ulaout_load = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.wb_sel      = 1'b0;
        bus.ula_seletor = ALU_ADD;
        bus.mux_a_sel   = MUXA_PC;
        bus.mux_b_sel   = MUXB_REGB;
        bus.halted      = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    bus.pc_old_load = (waitCount == 3'd0);
                    if (waitDone) begin
                        bus.ir_load   = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.mux_a_sel = MUXA_PC;
                        bus.mux_b_sel = MUXB_FOUR;
                    end
                end
                DECODE: begin
                    bus.ab_load     = 1'b1;
                    bus.ulaout_load = 1'b1;
                    bus.mux_a_sel   = MUXA_OLDPC;
                    bus.mux_b_sel   = MUXB_IMM;
                end
                EXEC_R: begin
                    bus.ulaout_load = 1'b1;
                    bus.mux_a_sel   = MUXA_REGA;
                    bus.mux_b_sel   = MUXB_REGB;
                    if (bus.funct3 == 3'b000 && bus.funct7_5) bus.ula_seletor = ALU_SUB;
                end
                EXEC_I, MEM_ADDR: begin
                    bus.ulaout_load = 1'b1;
                    bus.mux_a_sel   = MUXA_REGA;
                    bus.mux_b_sel   = MUXB_IMM;
                end
                LUI: begin
                    bus.ulaout_load = 1'b1;
                    bus.mux_a_sel   = MUXA_ZERO;
                    bus.mux_b_sel   = MUXB_IMM;
                end
                WB_ALU:    bus.reg_write = 1'b1;
                MEM_WRITE: bus.mem_write = 1'b1;
                WB_MEM: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = 1'b1;
                end
                BRANCH: begin
                    bus.ula_seletor = ALU_SUB;
                    bus.mux_a_sel   = MUXA_REGA;
                    bus.mux_b_sel   = MUXB_REGB;
                    if (branch_taken(bus.funct3, bus.igual)) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 1'b1;
                    end
                end
                HALT:    bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] retired_d;

    assign retired_d = (state_q != FETCH && state_d == FETCH) ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) retired_q <= 32'd0;
        else        retired_q <= retired_d;
    end

    assign bus.instr_retired = retired_q;
`else
    assign bus.instr_retired = 32'd0;
`endif
endmodule
